// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
// mc_control : multicycle RV32I control FSM driving ALU op/selects and enables
// Rev 1.0
// ============================================================================
module mc_control #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] alu_op,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [1:0] result_src,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       illegal
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_JALR     = 4'd10;
  localparam logic [3:0] S_LINK     = 4'd11;
  localparam logic [3:0] S_BRANCH   = 4'd12;
  localparam logic [3:0] S_LUI      = 4'd13;
  localparam logic [3:0] S_AUIPC    = 4'd14;
  localparam logic [3:0] S_ILLEGAL  = 4'd15;

  localparam logic [3:0] C_ADD  = 4'b0000;
  localparam logic [3:0] C_SUB  = 4'b0001;
  localparam logic [3:0] C_AND  = 4'b0010;
  localparam logic [3:0] C_OR   = 4'b0011;
  localparam logic [3:0] C_XOR  = 4'b0100;
  localparam logic [3:0] C_SLT  = 4'b0101;
  localparam logic [3:0] C_SLTU = 4'b0110;
  localparam logic [3:0] C_SLL  = 4'b0111;
  localparam logic [3:0] C_SRL  = 4'b1000;
  localparam logic [3:0] C_SRA  = 4'b1001;

  localparam logic [6:0] C_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] C_OPC_OP     = 7'b0110011;
  localparam logic [6:0] C_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] C_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] C_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] C_OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] C_IMM_I = 3'b000;
  localparam logic [2:0] C_IMM_S = 3'b001;
  localparam logic [2:0] C_IMM_B = 3'b010;
  localparam logic [2:0] C_IMM_J = 3'b011;
  localparam logic [2:0] C_IMM_U = 3'b100;

  logic [3:0] r_state;
  logic [3:0] w_cur;
  logic [3:0] w_next;
  logic       w_ir;
  logic       w_pc;
  logic       w_reg;
  logic       w_mem;
  logic       w_ill;

  // Shared funct3 decode; sub_ok is false for OP-IMM where bit 30 is immediate data.
  function automatic logic [3:0] f3_to_alu(input logic [2:0] f3, input logic sub_ok,
                                           input logic f75);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (sub_ok && f75) ? C_SUB : C_ADD;
      3'b001:  op = C_SLL;
      3'b010:  op = C_SLT;
      3'b011:  op = C_SLTU;
      3'b100:  op = C_XOR;
      3'b101:  op = f75 ? C_SRA : C_SRL;
      3'b110:  op = C_OR;
      default: op = C_AND;
    endcase
    return op;
  endfunction

  // During reset the selects follow FETCH while all enables are forced low.
  assign w_cur = reset ? S_FETCH : r_state;

  always_comb begin
    w_next     = w_cur;
    alu_op     = C_ADD;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    imm_src    = C_IMM_I;
    result_src = 2'b00;
    adr_src    = 1'b0;
    w_ir       = 1'b0;
    w_pc       = 1'b0;
    w_reg      = 1'b0;
    w_mem      = 1'b0;
    w_ill      = 1'b0;
    case (w_cur)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          w_ir   = 1'b1;
          w_pc   = 1'b1;
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          C_OPC_LOAD:   w_next = S_MEMADR;
          C_OPC_STORE:  begin imm_src = C_IMM_S; w_next = S_MEMADR; end
          C_OPC_OP:     w_next = S_EXECUTER;
          C_OPC_OPIMM:  w_next = S_EXECUTEI;
          C_OPC_JAL:    begin imm_src = C_IMM_J; w_next = S_JAL; end
          C_OPC_JALR:   w_next = S_JALR;
          C_OPC_BRANCH: begin imm_src = C_IMM_B; w_next = S_BRANCH; end
          C_OPC_LUI:    begin imm_src = C_IMM_U; w_next = S_LUI; end
          C_OPC_AUIPC:  begin imm_src = C_IMM_U; w_next = S_AUIPC; end
          default:      w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = opcode[5] ? C_IMM_S : C_IMM_I;
        w_next    = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        w_reg      = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        w_mem   = 1'b1;
        if (mem_ready) w_next = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = f3_to_alu(funct3, 1'b1, funct7_5);
        w_next    = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = f3_to_alu(funct3, 1'b0, funct7_5);
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg  = 1'b1;
        w_next = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        w_pc      = 1'b1;
        w_next    = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        w_pc       = 1'b1;
        w_next     = S_LINK;
      end
      S_LINK: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        w_reg      = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        w_next    = S_FETCH;
        case (funct3)
          3'b000:  begin alu_op = C_SUB;  w_pc = zero;  end
          3'b001:  begin alu_op = C_SUB;  w_pc = ~zero; end
          3'b100:  begin alu_op = C_SLT;  w_pc = ~zero; end
          3'b101:  begin alu_op = C_SLT;  w_pc = zero;  end
          3'b110:  begin alu_op = C_SLTU; w_pc = ~zero; end
          3'b111:  begin alu_op = C_SLTU; w_pc = zero;  end
          default: w_next = S_ILLEGAL;
        endcase
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        imm_src   = C_IMM_U;
        w_next    = S_ALUWB;
      end
      S_AUIPC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = C_IMM_U;
        w_next    = S_ALUWB;
      end
      default: begin
        w_ill  = 1'b1;
        w_next = S_ILLEGAL;
      end
    endcase
  end

  assign ir_write  = w_ir  & ~reset;
  assign pc_write  = w_pc  & ~reset;
  assign reg_write = w_reg & ~reset;
  assign mem_write = w_mem & ~reset;
  assign illegal   = w_ill & ~reset;

  always_ff @(posedge clk) begin
    if (reset) r_state <= RESET_STATE;
    else       r_state <= w_next;
  end

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// ============================================================================
// tb_mc_control : directed self-checking bench for mc_control
// Rev 1.0
// ============================================================================
module tb_mc_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       mem_ready;
  logic [3:0] alu_op;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] imm_src;
  logic [1:0] result_src;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic       mem_write;
  logic       illegal;

  mc_control #(.RESET_STATE(4'd0)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .alu_op(alu_op), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_src(imm_src), .result_src(result_src), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .mem_write(mem_write), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3, A_XOR = 4'd4;
  localparam logic [3:0] A_SLT = 4'd5, A_SLTU = 4'd6, A_SLL = 4'd7, A_SRL = 4'd8, A_SRA = 4'd9;

  // Field masks over obs = {alu_op, a, b, imm, res, adr, ir, pc, reg, mem, illegal}
  localparam logic [18:0] M_ALU = 19'h78000, M_A = 19'h06000, M_B = 19'h01800;
  localparam logic [18:0] M_IMM = 19'h00700, M_RES = 19'h000C0, M_ADR = 19'h00020;
  localparam logic [18:0] M_EN  = 19'h0001F;
  localparam logic [18:0] M_FETCH = M_ALU | M_A | M_B | M_RES | M_ADR | M_EN;

  logic [18:0] obs;
  logic [18:0] exp_v;
  logic [18:0] msk;
  int total  = 0;
  int passed = 0;

  assign obs = {alu_op, alu_src_a, alu_src_b, imm_src, result_src, adr_src,
                ir_write, pc_write, reg_write, mem_write, illegal};

  function automatic logic [18:0] pk(input logic [3:0] alu, input logic [1:0] a,
                                     input logic [1:0] b, input logic [2:0] imm,
                                     input logic [1:0] res, input logic adr,
                                     input logic [4:0] en);
    return {alu, a, b, imm, res, adr, en};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one instruction through FETCH with an immediate memory ready.
  task automatic fetch(input logic [6:0] op, input logic [2:0] f3, input logic f75);
    opcode = op; funct3 = f3; funct7_5 = f75; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b0; opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0; zero = 1'b0;
    tick(); tick();
    mem_ready = 1'b1; #1;
    exp_v = pk(A_ADD, 2'b00, 2'b10, 3'd0, 2'b10, 1'b0, 5'b00000); msk = M_EN;
    total++; if ((obs & msk) !== (exp_v & msk)) $display("FAIL reset_enables obs=%h exp=%h", obs & msk, exp_v & msk); else passed++;
    reset = 1'b0; mem_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      exp_v = pk(A_ADD, 2'b00, 2'b10, 3'd0, 2'b10, 1'b0, 5'b00000); msk = M_FETCH;
      total++; if ((obs & msk) !== (exp_v & msk)) $display("FAIL fetch_wait%0d obs=%h exp=%h", i, obs & msk, exp_v & msk); else passed++;
      tick();
    end
    mem_ready = 1'b1; #1;
    exp_v = pk(A_ADD, 2'b00, 2'b10, 3'd0, 2'b10, 1'b0, 5'b11000); msk = M_FETCH;
    total++; if ((obs & msk) !== (exp_v & msk)) $display("FAIL fetch_ready obs=%h exp=%h", obs & msk, exp_v & msk); else passed++;
    tick(); mem_ready = 1'b0; #1;
    exp_v = pk(A_ADD, 2'b01, 2'b01, 3'd0, 2'b00, 1'b0, 5'b00000); msk = M_ALU | M_A | M_B | M_EN;
    total++; if ((obs & msk) !== (exp_v & msk)) $display("FAIL decode_after_fetch obs=%h exp=%h", obs & msk, exp_v & msk); else passed++;
    reset = 1'b1; tick(); reset = 1'b0; #1;
  endtask

  task automatic test_rtype();
    logic [3:0] tbl [8];
    tbl = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
    fetch(7'b0110011, 3'b000, 1'b1);
    tick();
    exp_v = pk(A_SUB, 2'b10, 2'b00, 3'd0, 2'b00, 1'b0, 5'b00000); msk = M_ALU | M_A | M_B | M_EN;
    total++; if ((obs & msk) !== (exp_v & msk)) $display("FAIL executer_sub obs=%h exp=%h", obs & msk, exp_v & msk); else passed++;
    tick();
    exp_v = pk(A_ADD, 2'b00, 2'b00, 3'd0, 2'b00, 1'b0, 5'b00100); msk = M_RES | M_EN;
    total++; if ((obs & msk) !== (exp_v & msk)) $display("FAIL aluwb obs=%h exp=%h", obs & msk, exp_v & msk); else passed++;
    tick();
    exp_v = pk(A_ADD, 2'b00, 2'b10, 3'd0, 2'b10, 1'b0, 5'b00000); msk = M_FETCH;
    total++; if ((obs & msk) !== (exp_v & msk)) $display("FAIL rtype_back_to_fetch obs=%h exp=%h", obs & msk, exp_v & msk); else passed++;
    for (int f = 0; f < 8; f++) begin
      fetch(7'b0110011, 3'(f), 1'b0);
      tick();
      total++; if (alu_op !== tbl[f]) $display("FAIL r_sweep_f3_%0d obs=%h exp=%h", f, alu_op, tbl[f]); else passed++;
      tick(); tick();
    end
    fetch(7'b0110011, 3'b101, 1'b1); tick();
    total++; if (alu_op !== A_SRA) $display("FAIL r_sra obs=%h exp=%h", alu_op, A_SRA); else passed++;
    tick(); tick();
    fetch(7'b0010011, 3'b000, 1'b1); tick();
    exp_v = pk(A_ADD, 2'b10, 2'b01, 3'd0, 2'b00, 1'b0, 5'b00000); msk = M_ALU | M_A | M_B | M_IMM | M_EN;
    total++; if ((obs & msk) !== (exp_v & msk)) $display("FAIL executei_addi obs=%h exp=%h", obs & msk, exp_v & msk); else passed++;
    tick(); tick();
    fetch(7'b0010011, 3'b101, 1'b1); tick();
    total++; if (alu_op !== A_SRA) $display("FAIL executei_srai obs=%h exp=%h", alu_op, A_SRA); else passed++;
    tick(); tick();
  endtask

  task automatic test_load_store();
    fetch(7'b0000011, 3'b010, 1'b0);
    total++; if (imm_src !== 3'b000) $display("FAIL load_decode_imm obs=%h exp=%h", imm_src, 3'b000); else passed++;
    tick();
    exp_v = pk(A_ADD, 2'b10, 2'b01, 3'b000, 2'b00, 1'b0, 5'b00000); msk = M_ALU | M_A | M_B | M_IMM | M_EN;
    total++; if ((obs & msk) !== (exp_v & msk)) $display("FAIL load_memadr obs=%h exp=%h", obs & msk, exp_v & msk); else passed++;
    tick();
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i == 2); #1;
      exp_v = pk(A_ADD, 2'b00, 2'b00, 3'd0, 2'b00, 1'b1, 5'b00000); msk = M_RES | M_ADR | M_EN;
      total++; if ((obs & msk) !== (exp_v & msk)) $display("FAIL memread_cyc%0d obs=%h exp=%h", i, obs & msk, exp_v & msk); else passed++;
      tick();
    end
    mem_ready = 1'b0; #1;
    exp_v = pk(A_ADD, 2'b00, 2'b00, 3'd0, 2'b01, 1'b0, 5'b00100); msk = M_RES | M_EN;
    total++; if ((obs & msk) !== (exp_v & msk)) $display("FAIL memwb obs=%h exp=%h", obs & msk, exp_v & msk); else passed++;
    tick();
    fetch(7'b0100011, 3'b010, 1'b0);
    total++; if (imm_src !== 3'b001) $display("FAIL store_decode_imm obs=%h exp=%h", imm_src, 3'b001); else passed++;
    tick();
    total++; if (imm_src !== 3'b001) $display("FAIL store_memadr_imm obs=%h exp=%h", imm_src, 3'b001); else passed++;
    tick();
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i == 2); #1;
      exp_v = pk(A_ADD, 2'b00, 2'b00, 3'd0, 2'b00, 1'b1, 5'b00010); msk = M_ADR | M_EN;
      total++; if ((obs & msk) !== (exp_v & msk)) $display("FAIL memwrite_cyc%0d obs=%h exp=%h", i, obs & msk, exp_v & msk); else passed++;
      tick();
    end
    mem_ready = 1'b0; #1;
    exp_v = pk(A_ADD, 2'b00, 2'b10, 3'd0, 2'b10, 1'b0, 5'b00000); msk = M_FETCH;
    total++; if ((obs & msk) !== (exp_v & msk)) $display("FAIL store_back_to_fetch obs=%h exp=%h", obs & msk, exp_v & msk); else passed++;
  endtask

  task automatic test_branch();
    fetch(7'b1100011, 3'b000, 1'b0);
    total++; if (imm_src !== 3'b010) $display("FAIL branch_decode_imm obs=%h exp=%h", imm_src, 3'b010); else passed++;
    tick();
    zero = 1'b1; #1;
    exp_v = pk(A_SUB, 2'b10, 2'b00, 3'd0, 2'b00, 1'b0, 5'b01000); msk = M_ALU | M_A | M_B | M_RES | M_EN;
    total++; if ((obs & msk) !== (exp_v & msk)) $display("FAIL beq_taken obs=%h exp=%h", obs & msk, exp_v & msk); else passed++;
    zero = 1'b0; #1;
    exp_v = pk(A_SUB, 2'b10, 2'b00, 3'd0, 2'b00, 1'b0, 5'b00000);
    total++; if ((obs & msk) !== (exp_v & msk)) $display("FAIL beq_not_taken obs=%h exp=%h", obs & msk, exp_v & msk); else passed++;
    tick();
    fetch(7'b1100011, 3'b101, 1'b0); tick();
    exp_v = pk(A_SLT, 2'b10, 2'b00, 3'd0, 2'b00, 1'b0, 5'b00000); msk = M_ALU | M_EN;
    total++; if ((obs & msk) !== (exp_v & msk)) $display("FAIL bge_not_taken obs=%h exp=%h", obs & msk, exp_v & msk); else passed++;
    tick();
    fetch(7'b1100011, 3'b010, 1'b0); tick();
    zero = 1'b1; #1;
    total++; if (pc_write !== 1'b0) $display("FAIL branch_bad_f3_pc obs=%b exp=0", pc_write); else passed++;
    tick(); zero = 1'b0; #1;
    total++; if (illegal !== 1'b1) $display("FAIL branch_bad_f3_illegal obs=%b exp=1", illegal); else passed++;
    reset = 1'b1; tick(); reset = 1'b0; #1;
  endtask

  task automatic test_jumps();
    fetch(7'b1101111, 3'b000, 1'b0);
    total++; if (imm_src !== 3'b011) $display("FAIL jal_decode_imm obs=%h exp=%h", imm_src, 3'b011); else passed++;
    tick();
    exp_v = pk(A_ADD, 2'b01, 2'b10, 3'd0, 2'b00, 1'b0, 5'b01000); msk = M_ALU | M_A | M_B | M_RES | M_EN;
    total++; if ((obs & msk) !== (exp_v & msk)) $display("FAIL jal obs=%h exp=%h", obs & msk, exp_v & msk); else passed++;
    tick();
    exp_v = pk(A_ADD, 2'b00, 2'b00, 3'd0, 2'b00, 1'b0, 5'b00100); msk = M_RES | M_EN;
    total++; if ((obs & msk) !== (exp_v & msk)) $display("FAIL jal_aluwb obs=%h exp=%h", obs & msk, exp_v & msk); else passed++;
    tick();
    fetch(7'b1100111, 3'b000, 1'b0); tick();
    exp_v = pk(A_ADD, 2'b10, 2'b01, 3'b000, 2'b10, 1'b0, 5'b01000); msk = M_ALU | M_A | M_B | M_IMM | M_RES | M_EN;
    total++; if ((obs & msk) !== (exp_v & msk)) $display("FAIL jalr obs=%h exp=%h", obs & msk, exp_v & msk); else passed++;
    tick();
    exp_v = pk(A_ADD, 2'b01, 2'b10, 3'd0, 2'b10, 1'b0, 5'b00100); msk = M_ALU | M_A | M_B | M_RES | M_EN;
    total++; if ((obs & msk) !== (exp_v & msk)) $display("FAIL link obs=%h exp=%h", obs & msk, exp_v & msk); else passed++;
    tick();
    fetch(7'b0110111, 3'b000, 1'b0);
    total++; if (imm_src !== 3'b100) $display("FAIL lui_decode_imm obs=%h exp=%h", imm_src, 3'b100); else passed++;
    tick();
    exp_v = pk(A_ADD, 2'b11, 2'b01, 3'b100, 2'b00, 1'b0, 5'b00000); msk = M_ALU | M_A | M_B | M_IMM | M_EN;
    total++; if ((obs & msk) !== (exp_v & msk)) $display("FAIL lui obs=%h exp=%h", obs & msk, exp_v & msk); else passed++;
    tick(); tick();
    fetch(7'b0010111, 3'b000, 1'b0); tick();
    exp_v = pk(A_ADD, 2'b01, 2'b01, 3'b100, 2'b00, 1'b0, 5'b00000);
    total++; if ((obs & msk) !== (exp_v & msk)) $display("FAIL auipc obs=%h exp=%h", obs & msk, exp_v & msk); else passed++;
    tick(); tick();
  endtask

  task automatic test_illegal_and_reset();
    fetch(7'b1111111, 3'b000, 1'b0); tick();
    mem_ready = 1'b1; #1;
    for (int i = 0; i < 10; i++) begin
      total++; if ((obs & M_EN) !== 19'h00001) $display("FAIL illegal_sticky%0d obs=%h exp=%h", i, obs & M_EN, 19'h00001); else passed++;
      tick();
    end
    mem_ready = 1'b0; reset = 1'b1; tick(); reset = 1'b0; #1;
    exp_v = pk(A_ADD, 2'b00, 2'b10, 3'd0, 2'b10, 1'b0, 5'b00000); msk = M_FETCH;
    total++; if ((obs & msk) !== (exp_v & msk)) $display("FAIL illegal_cleared obs=%h exp=%h", obs & msk, exp_v & msk); else passed++;
    fetch(7'b0100011, 3'b010, 1'b0); tick(); tick();
    total++; if (mem_write !== 1'b1) $display("FAIL memwrite_wait obs=%b exp=1", mem_write); else passed++;
    reset = 1'b1; #1;
    total++; if ((obs & M_EN) !== 19'h0) $display("FAIL reset_mid_en obs=%h exp=0", obs & M_EN); else passed++;
    tick(); reset = 1'b0; #1;
    total++; if ((obs & msk) !== (exp_v & msk)) $display("FAIL reset_mid_fetch obs=%h exp=%h", obs & msk, exp_v & msk); else passed++;
    mem_ready = 1'b1; #1;
    total++; if ((obs & M_EN) !== 19'h00018) $display("FAIL reset_mid_refetch obs=%h exp=%h", obs & M_EN, 19'h00018); else passed++;
    tick(); mem_ready = 1'b0; #1;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_store();
    test_branch();
    test_jumps();
    test_illegal_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
